// File: rtl/line_capture.sv
// rtl/line_capture.sv - ADC line capture: settle-delayed pixel sampling into a line buffer, then streamed readout.
module line_capture #(
  parameter int PIXELS = 1024,
  parameter int DW     = 12,
  parameter int SETTLE = 4
) (
  input  logic          FPGA_CLK,
  input  logic          FPGA_RST,
  input  logic          EOC_EDGE_FF,
  input  logic          EOS_EDGE_FF,
  input  logic [DW-1:0] ADC_DATA,
  input  logic          CLR_FLAGS,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic [10:0]   LINE_LEN,
  output logic          LINE_DONE,
  output logic          OVERFLOW,
  output logic          LINE_MISSED
);

  localparam int          AW  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [10:0] PIX = 11'(PIXELS);

  typedef enum logic {CAPTURE, READOUT} state_t;

  state_t        state_q, state_d;
  logic [10:0]   len_q, len_d;    // doubles as the write pointer
  logic [10:0]   rd_q, rd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          arm_q, arm_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          miss_q, miss_d;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_q;
  logic [DW-1:0] line_buf [PIXELS];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    arm_d   = arm_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ovf_d   = CLR_FLAGS ? 1'b0 : ovf_q;
    miss_d  = CLR_FLAGS ? 1'b0 : miss_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    case (state_q)
      CAPTURE: begin
        if (pend_q) begin
          if (cnt_q == 4'd0) begin
            pend_d = 1'b0;
            wr_en  = 1'b1;
            len_d  = len_q + 11'd1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        // EOS has priority; a coincident EOC is silently dropped
        if (EOS_EDGE_FF) begin
          if (len_q != 11'd0) begin
            state_d = READOUT;
            pend_d  = 1'b0;
            wr_en   = 1'b0;
            len_d   = len_q;
            rd_d    = 11'd0;
            arm_d   = 1'b0;
          end
        end else if (EOC_EDGE_FF) begin
          if (pend_q || len_q == PIX) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = 1'b1;
            cnt_d  = 4'(SETTLE - 1);
          end
        end
      end

      READOUT: begin
        if (EOS_EDGE_FF) miss_d = 1'b1;
        // one idle cycle after entry keeps first valid at EOS+3
        if (!arm_q) begin
          arm_d = 1'b1;
        end else if (valid_q && OUT_READY && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          len_d   = 11'd0;
          state_d = CAPTURE;
        end else if ((!valid_q || OUT_READY) && rd_q < len_q) begin
          rd_en   = 1'b1;
          valid_d = 1'b1;
          last_d  = (rd_q == len_q - 11'd1);
          rd_d    = rd_q + 11'd1;
        end
      end

      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state_q <= CAPTURE;
      len_q   <= 11'd0;
      rd_q    <= 11'd0;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (wr_en) line_buf[len_q[AW-1:0]] <= ADC_DATA;
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= line_buf[rd_q[AW-1:0]];
    end
  end

  assign OUT_DATA    = data_q;
  assign OUT_VALID   = valid_q;
  assign OUT_LAST    = last_q;
  assign LINE_LEN    = len_q;
  assign LINE_DONE   = done_q;
  assign OVERFLOW    = ovf_q;
  assign LINE_MISSED = miss_q;

endmodule

// File: tb/tb_line_capture.sv
// tb/tb_line_capture.sv - directed bench for line_capture (PIXELS=8, SETTLE=4).
module tb_line_capture;

  localparam int PIXELS = 8;
  localparam int DW     = 12;
  localparam int SETTLE = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          eoc   = 1'b0;
  logic          eos   = 1'b0;
  logic          clr   = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] adc   = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, line_done, overflow, line_missed;
  logic [10:0]   line_len;

  int vectors     = 0;
  int miscompares = 0;

  line_capture #(.PIXELS(PIXELS), .DW(DW), .SETTLE(SETTLE)) dut (
    .FPGA_CLK   (clk),
    .FPGA_RST   (rst),
    .EOC_EDGE_FF(eoc),
    .EOS_EDGE_FF(eos),
    .ADC_DATA   (adc),
    .CLR_FLAGS  (clr),
    .OUT_DATA   (out_data),
    .OUT_VALID  (out_valid),
    .OUT_READY  (ready),
    .OUT_LAST   (out_last),
    .LINE_LEN   (line_len),
    .LINE_DONE  (line_done),
    .OVERFLOW   (overflow),
    .LINE_MISSED(line_missed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ADC bus carries junk except in the cycle SETTLE after the pulse
  task automatic capture_pixel(input logic [DW-1:0] d);
    eoc = 1'b1; adc = 12'hEEE; step();
    eoc = 1'b0;
    for (int i = 1; i < SETTLE; i++) step();
    adc = d; step();
    adc = 12'hEEE;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic pulse_eos();
    eos = 1'b1; step(); eos = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    vectors++;
    if ({out_valid, out_last, line_done, overflow, line_missed} !== 5'b0 ||
        out_data !== '0 || line_len !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%b o=%b m=%b data=%h len=%0d want all zero",
               out_valid, out_last, line_done, overflow, line_missed, out_data, line_len);
    end
  endtask

  task automatic test_basic();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) capture_pixel(DW'(12'h101 + i));
    vectors++;
    if (line_len !== 11'd5 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_len: got len=%0d valid=%b want 5/0", line_len, out_valid);
    end
    pulse_eos();
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_latency: valid=%b at EOS+%0d want 0", out_valid, c);
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DW'(12'h101 + i) ||
          out_last !== (i == 4) || line_done !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got v=%b data=%h last=%b done=%b want 1/%h/%b/0",
                 i, out_valid, out_data, out_last, line_done, 12'h101 + i, i == 4);
      end
      step();
    end
    vectors++;
    if (line_done !== 1'b1 || out_valid !== 1'b0 || line_len !== 11'd0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b valid=%b len=%0d want 1/0/0", line_done, out_valid, line_len);
    end
    step();
    vectors++;
    if (line_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done=%b want 0", line_done);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int c = 0;
    logic stalled = 1'b0;
    logic done_seen = 1'b0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    for (int i = 0; i < 5; i++) capture_pixel(DW'(12'h101 + i));
    pulse_eos();
    while (c < 60 && !done_seen) begin
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          miscompares++;
          $display("FAIL bp_stable: got v=%b data=%h last=%b want 1/%h/%b", out_valid, out_data, out_last, pd, pl);
        end
      end
      if (line_done) begin
        done_seen = 1'b1;
      end else begin
        ready = (c % 3 == 0);
        if (out_valid && ready) begin
          vectors++;
          if (out_data !== DW'(12'h101 + idx) || out_last !== (idx == 4)) begin
            miscompares++;
            $display("FAIL bp_beat%0d: got data=%h last=%b want %h/%b", idx, out_data, out_last, 12'h101 + idx, idx == 4);
          end
          idx++;
        end
        stalled = out_valid && !ready;
        pd = out_data;
        pl = out_last;
        step();
        c++;
      end
    end
    vectors++;
    if (idx != 5 || !done_seen) begin
      miscompares++;
      $display("FAIL bp_count: got beats=%0d done=%b want 5/1", idx, done_seen);
    end
    ready = 1'b1;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) capture_pixel(DW'(12'h201 + i));
    vectors++;
    if (line_len !== 11'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_full: got len=%0d ovf=%b want 8/0", line_len, overflow);
    end
    capture_pixel(12'h209);
    capture_pixel(12'h20A);
    vectors++;
    if (line_len !== 11'd8 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got len=%0d ovf=%b want 8/1", line_len, overflow);
    end
    pulse_eos(); step(); step();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DW'(12'h201 + i) || out_last !== (i == 7)) begin
        miscompares++;
        $display("FAIL ovf_beat%0d: got v=%b data=%h last=%b want 1/%h/%b", i, out_valid, out_data, out_last, 12'h201 + i, i == 7);
      end
      step();
    end
    vectors++;
    if (line_done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_done: got done=%b valid=%b want 1/0", line_done, out_valid);
    end
    clr = 1'b1; step(); clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_collision();
    adc = 12'hEEE;
    eoc = 1'b1; step(); eoc = 1'b0; step();
    eoc = 1'b1; step(); eoc = 1'b0; step();
    adc = 12'h301; step(); adc = 12'hEEE;
    step(); adc = 12'h3FF; step(); adc = 12'hEEE;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (line_len !== 11'd1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_settle: got len=%0d ovf=%b want 1/1", line_len, overflow);
    end
    clr = 1'b1; step(); clr = 1'b0;
    eoc = 1'b1; eos = 1'b1; step(); eoc = 1'b0; eos = 1'b0;
    step(); step();
    vectors++;
    if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'h301 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_eoc_eos: got ovf=%b v=%b data=%h last=%b want 0/1/301/1", overflow, out_valid, out_data, out_last);
    end
    step();
    vectors++;
    if (line_done !== 1'b1 || line_len !== 11'd0) begin
      miscompares++;
      $display("FAIL coll_done: got done=%b len=%0d want 1/0", line_done, line_len);
    end
    step();
  endtask

  task automatic test_eos_in_readout();
    capture_pixel(12'h401);
    capture_pixel(12'h402);
    pulse_eos(); step(); step();
    eos = 1'b1; eoc = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h401 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_beat0: got v=%b data=%h last=%b want 1/401/0", out_valid, out_data, out_last);
    end
    step(); eos = 1'b0; eoc = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h402 || out_last !== 1'b1 ||
        line_missed !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_beat1: got v=%b data=%h last=%b miss=%b ovf=%b want 1/402/1/1/0",
               out_valid, out_data, out_last, line_missed, overflow);
    end
    step();
    vectors++;
    if (line_done !== 1'b1 || line_len !== 11'd0) begin
      miscompares++;
      $display("FAIL miss_done: got done=%b len=%0d want 1/0", line_done, line_len);
    end
    clr = 1'b1; step(); clr = 1'b0;
    vectors++;
    if (line_missed !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_clear: miss=%b want 0", line_missed);
    end
    pulse_eos();
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || line_done !== 1'b0) begin
        miscompares++;
        $display("FAIL empty_eos: cycle %0d v=%b done=%b want 0/0", c, out_valid, line_done);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) capture_pixel(DW'(12'h501 + i));
    pulse_eos(); step(); step();
    eos = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h501) begin
      miscompares++;
      $display("FAIL rst_beat0: got v=%b data=%h want 1/501", out_valid, out_data);
    end
    step(); eos = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h502 || line_missed !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_beat1: got v=%b data=%h miss=%b want 1/502/1", out_valid, out_data, line_missed);
    end
    step();
    rst = 1'b1; step(); rst = 1'b0;
    vectors++;
    if ({out_valid, out_last, line_done, overflow, line_missed} !== 5'b0 ||
        out_data !== '0 || line_len !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_abort: got v=%b l=%b d=%b o=%b m=%b data=%h len=%0d want all zero",
               out_valid, out_last, line_done, overflow, line_missed, out_data, line_len);
    end
    capture_pixel(12'h601);
    vectors++;
    if (line_len !== 11'd1) begin
      miscompares++;
      $display("FAIL rst_recapture_len: len=%0d want 1", line_len);
    end
    pulse_eos(); step(); step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h601 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_recapture_beat: got v=%b data=%h last=%b want 1/601/1", out_valid, out_data, out_last);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_collision();
    test_eos_in_readout();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_capture.md
LINE_CAPTURE -- requirements
Module: line_capture

Interface
REQ-001 Parameters SHALL be: PIXELS, default 1024, line buffer depth and maximum samples per line; DW, default 12, ADC sample width; SETTLE, default 4, FPGA_CLK cycles from EOC pulse to ADC sampling (range 1-15).
REQ-002 The block SHALL use one clock and one reset: FPGA_CLK is the sole clock, and FPGA_RST is a synchronous, active-high reset.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- FPGA_CLK, in, 1, system clock.
- FPGA_RST, in, 1, synchronous active-high reset.
- EOC_EDGE_FF, in, 1, one-cycle pulse per pixel conversion end.
- EOS_EDGE_FF, in, 1, one-cycle pulse at end of scan.
- ADC_DATA, in, DW, parallel ADC sample.
- CLR_FLAGS, in, 1, clears sticky flags.
- OUT_DATA, out, DW, pixel sample.
- OUT_VALID, out, 1, OUT_DATA valid.
- OUT_READY, in, 1, consumer accepts.
- OUT_LAST, out, 1, final pixel of line.
- LINE_LEN, out, 11, pixels captured in the current/last line.
- LINE_DONE, out, 1, one-cycle pulse after the last handshake.
- OVERFLOW, out, 1, sticky: pixel beyond PIXELS or EOC during settle.
- LINE_MISSED, out, 1, sticky: EOS received during READOUT.

Function
REQ-004 States SHALL be CAPTURE and READOUT; after reset the block is in CAPTURE.
REQ-005 CAPTURE: an EOC pulse with no sample pending SHALL start a settle countdown; exactly SETTLE cycles after the pulse cycle, ADC_DATA SHALL be written to buffer[wr_ptr], and wr_ptr and LINE_LEN SHALL increment by 1.
REQ-006 An EOC pulse while a sample is pending SHALL be ignored and SHALL set OVERFLOW.
REQ-007 An EOC pulse when wr_ptr == PIXELS SHALL write nothing and SHALL set OVERFLOW; wr_ptr SHALL never wrap.
REQ-008 An EOS pulse in CAPTURE with LINE_LEN > 0 SHALL enter READOUT on the next cycle and SHALL discard any pending sample.
REQ-009 An EOS pulse in CAPTURE with LINE_LEN == 0 SHALL leave the block in CAPTURE with no output activity.
REQ-010 Simultaneous EOC and EOS in CAPTURE: EOS SHALL win and the EOC SHALL be dropped without setting OVERFLOW.
REQ-011 READOUT: samples 0..LINE_LEN-1 SHALL be streamed in order on OUT_DATA using a VALID/READY handshake, where a transfer occurs on each cycle with OUT_VALID && OUT_READY.
REQ-012 If EOS occurs in cycle T, OUT_VALID SHALL first assert in cycle T+3.
REQ-013 With OUT_READY held high, one sample SHALL transfer per cycle with no bubbles.
REQ-014 While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_LAST and OUT_VALID SHALL hold stable.
REQ-015 OUT_LAST SHALL be 1 exactly with sample LINE_LEN-1.
REQ-016 OUT_VALID SHALL never assert outside READOUT.
REQ-017 The cycle after the OUT_LAST transfer, the block SHALL pulse LINE_DONE for one cycle, return to CAPTURE, and clear wr_ptr and LINE_LEN to 0.
REQ-018 EOC pulses in READOUT SHALL be ignored without setting a flag.
REQ-019 An EOS pulse in READOUT SHALL set LINE_MISSED.
REQ-020 CLR_FLAGS=1 SHALL clear OVERFLOW and LINE_MISSED on the next cycle.
REQ-021 If CLR_FLAGS and a set condition occur in the same cycle, set SHALL win.
REQ-022 LINE_LEN SHALL saturate at PIXELS.

Reset
REQ-023 FPGA_RST=1 at a clock edge SHALL force: state CAPTURE, wr_ptr 0, LINE_LEN 0, pending sample cleared, OUT_VALID 0, OUT_LAST 0, OUT_DATA 0, LINE_DONE 0, OVERFLOW 0, LINE_MISSED 0.
REQ-024 Reset asserted mid-READOUT SHALL abort the stream immediately, with OUT_VALID low on the cycle following the reset edge.
REQ-025 Buffer contents need not be cleared by reset.

Verification
REQ-026 Basic line: SETTLE=4, PIXELS=8; 5 EOC pulses 10 cycles apart with ADC_DATA = 0x101..0x105 at the sample cycles, then EOS, OUT_READY=1 -> OUT_DATA 0x101..0x105 on consecutive cycles, first beat at EOS+3, OUT_LAST on 0x105, LINE_DONE one cycle later, LINE_LEN 5 then 0.
REQ-027 Backpressure: same line, OUT_READY toggling 1,0,0,1,... -> every sample delivered exactly once and in order, outputs stable while stalled.
REQ-028 Overflow: PIXELS=8, 10 EOC pulses -> LINE_LEN 8, OVERFLOW=1, readout of 8 samples; CLR_FLAGS -> OVERFLOW=0.
REQ-029 Collisions: EOC pulses 2 cycles apart with SETTLE=4 -> second pulse dropped, OVERFLOW=1; EOC and EOS in the same cycle -> EOC dropped, OVERFLOW unchanged.
REQ-030 EOS during READOUT -> LINE_MISSED=1, stream unaffected; EOS with LINE_LEN=0 -> no OUT_VALID.
REQ-031 Reset mid-READOUT after 2 of 5 beats -> OUT_VALID=0 next cycle, all outputs at reset values, a new line captures normally.
